// File: rtl/if_prefetch_pkg.sv
// Shared constants and helpers for the prefetching instruction-fetch stage.
package if_prefetch_pkg;

  localparam int PC_INC     = 4;
  // Low address bits that must be clear on every fetch target.
  localparam int ALIGN_MASK = 3;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/if_prefetch_if.sv
// Decode-side, redirect and instruction-memory signals of the fetch stage.
interface if_prefetch_if #(
  parameter int INST_SZ = 32,
  parameter int PC_SZ   = 32,
  parameter int DEPTH   = 4
);
  import if_prefetch_pkg::*;

  localparam int CNT_W = clog2(DEPTH) + 1;

  logic               i_enable;
  logic               i_pc_src_D;
  logic               i_jump_D;
  logic               i_jump_sel_D;
  logic [PC_SZ-1:0]   i_branch_addr_D;
  logic [PC_SZ-1:0]   i_jump_addr_D;
  logic [PC_SZ-1:0]   i_rs_addr_D;
  logic               i_ready_D;
  logic               o_imem_en;
  logic [PC_SZ-1:0]   o_imem_addr;
  logic [INST_SZ-1:0] i_imem_data;
  logic               o_valid_F;
  logic [INST_SZ-1:0] o_instruction_F;
  logic [PC_SZ-1:0]   o_pc;
  logic [PC_SZ-1:0]   o_npc_F;
  logic [PC_SZ-1:0]   o_branch_delay_slot_F;
  logic [CNT_W-1:0]   o_count;

  modport master (
    input  i_enable, i_pc_src_D, i_jump_D, i_jump_sel_D,
    input  i_branch_addr_D, i_jump_addr_D, i_rs_addr_D, i_ready_D, i_imem_data,
    output o_imem_en, o_imem_addr, o_valid_F, o_instruction_F,
    output o_pc, o_npc_F, o_branch_delay_slot_F, o_count
  );

  modport slave (
    output i_enable, i_pc_src_D, i_jump_D, i_jump_sel_D,
    output i_branch_addr_D, i_jump_addr_D, i_rs_addr_D, i_ready_D, i_imem_data,
    input  o_imem_en, o_imem_addr, o_valid_F, o_instruction_F,
    input  o_pc, o_npc_F, o_branch_delay_slot_F, o_count
  );

endinterface

// File: rtl/if_prefetch_fetch_queue.sv
// Synchronous FIFO of {pc, instruction} entries with flush; head is read combinationally.
module if_prefetch_fetch_queue
  import if_prefetch_pkg::*;
#(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [W-1:0]             head,
  output logic                     valid,
  output logic [clog2(DEPTH):0]    count
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             not_empty;
  logic             pop_ok;
  logic             push_ok;

  assign not_empty = (count_reg != '0);
  assign pop_ok    = pop & not_empty & ~flush;
  // A push at full is only legal when the head leaves in the same cycle.
  assign push_ok   = push & ~flush & ((count_reg != CNT_W'(DEPTH)) | pop_ok);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_data;
  end

  assign head  = mem[rd_ptr_reg];
  assign valid = not_empty;
  assign count = count_reg;

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch stage issuing sequential fetches into a prefetch queue ahead of decode.
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int               INST_SZ  = 32,
  parameter int               PC_SZ    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [PC_SZ-1:0] RESET_PC = '0
) (
  input  logic          i_clk,
  input  logic          i_reset,
  if_prefetch_if.master bus
);

  localparam int CNT_W   = clog2(DEPTH) + 1;
  localparam int ENTRY_W = PC_SZ + INST_SZ;

  logic               redirect;
  logic [PC_SZ-1:0]   target_raw;
  logic [PC_SZ-1:0]   target;
  logic [PC_SZ-1:0]   fetch_pc_reg;
  logic [PC_SZ-1:0]   fetch_pc_next;
  logic [PC_SZ-1:0]   issue_addr;
  logic [PC_SZ-1:0]   inflight_addr_reg;
  logic               inflight_reg;
  logic               credit_ok;
  logic               issue;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] head;
  logic               q_valid;
  logic [CNT_W-1:0]   count;
  logic [PC_SZ-1:0]   head_pc;
  logic [PC_SZ-1:0]   last_pc_reg;
  logic [INST_SZ-1:0] last_inst_reg;

  assign redirect = bus.i_jump_sel_D | bus.i_jump_D | bus.i_pc_src_D;

  always_comb begin
    target_raw = bus.i_branch_addr_D;
    if (bus.i_jump_sel_D)  target_raw = bus.i_rs_addr_D;
    else if (bus.i_jump_D) target_raw = bus.i_jump_addr_D;
  end

  assign target = target_raw & ~PC_SZ'(ALIGN_MASK);

  // Queued plus in-flight entries may never exceed DEPTH; a redirect frees every credit.
  assign credit_ok  = (count + CNT_W'(inflight_reg)) < CNT_W'(DEPTH);
  assign issue      = i_reset & bus.i_enable & (redirect | credit_ok);
  assign issue_addr = redirect ? target : fetch_pc_reg;

  always_comb begin
    fetch_pc_next = issue_addr;
    if (issue) fetch_pc_next = issue_addr + PC_SZ'(PC_INC);
  end

  // The response arriving in a redirect cycle belongs to the old stream and is dropped.
  assign push = inflight_reg & ~redirect;
  assign pop  = q_valid & bus.i_ready_D;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      fetch_pc_reg      <= RESET_PC;
      inflight_reg      <= 1'b0;
      inflight_addr_reg <= '0;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      inflight_reg <= issue;
      if (issue) inflight_addr_reg <= issue_addr;
    end
  end

  if_prefetch_fetch_queue #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .push      (push),
    .push_data ({inflight_addr_reg, bus.i_imem_data}),
    .pop       (pop),
    .flush     (redirect),
    .head      (head),
    .valid     (q_valid),
    .count     (count)
  );

  // Remember the last shown head so the outputs hold steady while the queue is empty.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      last_pc_reg   <= '0;
      last_inst_reg <= '0;
    end else if (q_valid) begin
      last_pc_reg   <= head[ENTRY_W-1:INST_SZ];
      last_inst_reg <= head[INST_SZ-1:0];
    end
  end

  assign head_pc                   = q_valid ? head[ENTRY_W-1:INST_SZ] : last_pc_reg;
  assign bus.o_pc                  = head_pc;
  assign bus.o_instruction_F       = q_valid ? head[INST_SZ-1:0] : last_inst_reg;
  assign bus.o_npc_F               = head_pc + PC_SZ'(PC_INC);
  assign bus.o_branch_delay_slot_F = head_pc + PC_SZ'(2 * PC_INC);
  assign bus.o_valid_F             = q_valid;
  assign bus.o_count               = count;
  assign bus.o_imem_en             = issue;
  assign bus.o_imem_addr           = issue_addr;

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch with a 1-cycle instruction memory model.
module tb_if_prefetch;

  localparam logic [31:0] SALT = 32'h5A5A_A5A5;

  logic clk;
  logic i_reset;
  int   checks;
  int   errors;
  logic [31:0] exp_pc;

  if_prefetch_if #(.INST_SZ(32), .PC_SZ(32), .DEPTH(4)) bus ();

  if_prefetch #(.INST_SZ(32), .PC_SZ(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .i_clk   (clk),
    .i_reset (i_reset),
    .bus     (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ SALT;
  endfunction

  always @(posedge clk) begin
    if (bus.o_imem_en) bus.i_imem_data <= inst_of(bus.o_imem_addr);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  // Any head accepted by decode (outside a redirect) must follow the expected stream.
  task automatic tick();
    #1;
    if (bus.o_valid_F && bus.i_ready_D && i_reset &&
        !(bus.i_pc_src_D || bus.i_jump_D || bus.i_jump_sel_D)) begin
      $display("pop pc=0x%08h inst=0x%08h", bus.o_pc, bus.o_instruction_F);
      check("seq_pc", bus.o_pc, exp_pc);
      check("seq_inst", bus.o_instruction_F, inst_of(exp_pc));
      exp_pc = exp_pc + 32'd4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fill_at(input logic [31:0] a);
    bus.i_pc_src_D      = 1'b1;
    bus.i_branch_addr_D = a;
    bus.i_ready_D       = 1'b0;
    tick();
    bus.i_pc_src_D = 1'b0;
    exp_pc = a;
    repeat (7) tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_pc = 32'h0;
    i_reset = 1'b0;
    bus.i_enable = 1'b0;
    bus.i_pc_src_D = 1'b0;
    bus.i_jump_D = 1'b0;
    bus.i_jump_sel_D = 1'b0;
    bus.i_branch_addr_D = '0;
    bus.i_jump_addr_D = '0;
    bus.i_rs_addr_D = '0;
    bus.i_ready_D = 1'b0;
    bus.i_imem_data = '0;

    repeat (2) @(posedge clk);
    #1;
    bus.i_enable = 1'b1;
    #1;
    check("rst_valid", bus.o_valid_F, 1'b0);
    check("rst_count", bus.o_count, 3'd0);
    check("rst_imem_en", bus.o_imem_en, 1'b0);
    check("rst_pc", bus.o_pc, 32'h0);
    check("rst_inst", bus.o_instruction_F, 32'h0);

    // Sequential start-up from RESET_PC.
    i_reset = 1'b1;
    bus.i_ready_D = 1'b1;
    #1;
    check("c0_en", bus.o_imem_en, 1'b1);
    check("c0_addr", bus.o_imem_addr, 32'h0);
    tick();
    check("c1_addr", bus.o_imem_addr, 32'h4);
    check("c1_valid", bus.o_valid_F, 1'b0);
    tick();
    check("c2_valid", bus.o_valid_F, 1'b1);
    check("c2_pc", bus.o_pc, 32'h0);
    check("c2_addr", bus.o_imem_addr, 32'h8);
    tick();
    check("c3_pc", bus.o_pc, 32'h4);
    check("c3_npc", bus.o_npc_F, 32'h8);
    check("c3_bds", bus.o_branch_delay_slot_F, 32'hC);

    // Decode stall until the queue is full.
    bus.i_ready_D = 1'b0;
    repeat (10) tick();
    #1;
    check("full_count", bus.o_count, 3'd4);
    check("full_no_issue", bus.o_imem_en, 1'b0);
    bus.i_ready_D = 1'b1;
    repeat (10) tick();

    // Branch flushes a full queue; pop in the same cycle is ignored.
    fill_at(32'h10);
    check("fill_count", bus.o_count, 3'd4);
    check("fill_head", bus.o_pc, 32'h10);
    bus.i_pc_src_D = 1'b1;
    bus.i_branch_addr_D = 32'h100;
    bus.i_ready_D = 1'b1;
    #1;
    check("br_en", bus.o_imem_en, 1'b1);
    check("br_addr", bus.o_imem_addr, 32'h100);
    tick();
    bus.i_pc_src_D = 1'b0;
    exp_pc = 32'h100;
    #1;
    check("br_n1_valid", bus.o_valid_F, 1'b0);
    check("br_n1_count", bus.o_count, 3'd0);
    tick();
    check("br_n2_valid", bus.o_valid_F, 1'b1);
    check("br_n2_pc", bus.o_pc, 32'h100);
    repeat (3) tick();

    // Jump-register beats jump; the in-flight 0x20 response is killed.
    fill_at(32'h10);
    bus.i_ready_D = 1'b1;
    tick();
    bus.i_ready_D = 1'b0;
    #1;
    check("pre_jmp_en", bus.o_imem_en, 1'b1);
    check("pre_jmp_addr", bus.o_imem_addr, 32'h20);
    tick();
    bus.i_jump_D = 1'b1;
    bus.i_jump_addr_D = 32'h200;
    bus.i_jump_sel_D = 1'b1;
    bus.i_rs_addr_D = 32'h302;
    bus.i_ready_D = 1'b1;
    #1;
    check("jr_addr", bus.o_imem_addr, 32'h300);
    tick();
    bus.i_jump_D = 1'b0;
    bus.i_jump_sel_D = 1'b0;
    exp_pc = 32'h300;
    #1;
    check("jr_n1_valid", bus.o_valid_F, 1'b0);
    tick();
    check("jr_n2_pc", bus.o_pc, 32'h300);
    repeat (3) tick();

    // Address wrap at the top of the PC space.
    bus.i_pc_src_D = 1'b1;
    bus.i_branch_addr_D = 32'hFFFF_FFF8;
    tick();
    bus.i_pc_src_D = 1'b0;
    exp_pc = 32'hFFFF_FFF8;
    tick();
    check("wr_pc0", bus.o_pc, 32'hFFFF_FFF8);
    tick();
    check("wr_pc1", bus.o_pc, 32'hFFFF_FFFC);
    check("wr_npc1", bus.o_npc_F, 32'h0);
    check("wr_bds1", bus.o_branch_delay_slot_F, 32'h4);
    tick();
    check("wr_pc2", bus.o_pc, 32'h0);

    // Fetch disabled: no issue, queue drains, outputs hold the last head.
    bus.i_enable = 1'b0;
    #1;
    check("dis_no_issue", bus.o_imem_en, 1'b0);
    repeat (6) tick();
    check("dis_empty", bus.o_valid_F, 1'b0);
    check("dis_hold_pc", bus.o_pc, exp_pc - 32'd4);
    bus.i_enable = 1'b1;

    // Asynchronous reset in the middle of a full queue.
    fill_at(32'h40);
    check("pre_rst_count", bus.o_count, 3'd4);
    #2;
    i_reset = 1'b0;
    #1;
    check("arst_valid", bus.o_valid_F, 1'b0);
    check("arst_count", bus.o_count, 3'd0);
    check("arst_en", bus.o_imem_en, 1'b0);
    tick();
    i_reset = 1'b1;
    bus.i_ready_D = 1'b1;
    exp_pc = 32'h0;
    #1;
    check("rel_en", bus.o_imem_en, 1'b1);
    check("rel_addr", bus.o_imem_addr, 32'h0);
    tick();
    tick();
    check("rel_valid", bus.o_valid_F, 1'b1);
    check("rel_pc", bus.o_pc, 32'h0);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
